// File: rtl/axi4_types_pkg.sv
// Shared AXI4 types and constants; no logic, no latency.
// Read arbiter FSM encoding and fixed burst type; no handshakes live here.
package axi4_types_pkg;

    typedef enum logic [1:0] {
        IDLE_E     = 2'd0,
        AR_PHASE_E = 2'd1,
        R_PHASE_E  = 2'd2
    } read_arb_state_t;

    localparam logic [1:0] AXI4_BURST_INCR_C = 2'b01;
    localparam int         AXI4_BEAT_CNT_W_C = 9;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set request at or after i_rr_ptr, wrapping modulo N.
// Purely combinational, zero latency; no handshakes, so no backpressure.
module rr_priority_select #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic          o_any_req,
    output logic [IW-1:0] o_grant
);

    logic [2*N-1:0] w_dbl;

    assign w_dbl     = {i_req, i_req};
    assign o_any_req = |i_req;

    // Walk offsets from far to near so the closest requester after the pointer wins.
    always_comb begin
        o_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = int'(i_rr_ptr) + i;
            if (w_dbl[k]) begin
                if (k >= N) begin
                    k = k - N;
                end
                o_grant = IW'(k);
            end
        end
    end

endmodule

// File: rtl/axi4_m2s_read_arbiter.sv
// N-to-1 AXI4 read arbiter, one burst at a time; grant 1 cycle after request, AR/R paths are
// combinational from the registered grant so ready/valid pass straight through. Option: AXI4_RD_ARB_BEAT_CHECK_EN.
module axi4_m2s_read_arbiter
    import axi4_types_pkg::*;
#(
    parameter int AXI_ID_WIDTH_P   = 3,
    parameter int AXI_ADDR_WIDTH_P = 32,
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int NR_OF_MASTERS_P  = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NR_OF_MASTERS_P-1:0][AXI_ID_WIDTH_P-1:0]   mst_arid,
    input  logic [NR_OF_MASTERS_P-1:0][AXI_ADDR_WIDTH_P-1:0] mst_araddr,
    input  logic [NR_OF_MASTERS_P-1:0][7:0]                  mst_arlen,
    input  logic [NR_OF_MASTERS_P-1:0]                       mst_arvalid,
    output logic [NR_OF_MASTERS_P-1:0]                       mst_arready,
    output logic [AXI_ID_WIDTH_P-1:0]                        mst_rid,
    output logic [AXI_DATA_WIDTH_P-1:0]                      mst_rdata,
    output logic [1:0]                                       mst_rresp,
    output logic                                             mst_rlast,
    output logic [NR_OF_MASTERS_P-1:0]                       mst_rvalid,
    input  logic [NR_OF_MASTERS_P-1:0]                       mst_rready,
    output logic [AXI_ID_WIDTH_P-1:0]                        slv_arid,
    output logic [AXI_ADDR_WIDTH_P-1:0]                      slv_araddr,
    output logic [7:0]                                       slv_arlen,
    output logic [2:0]                                       slv_arsize,
    output logic [1:0]                                       slv_arburst,
    output logic                                             slv_arlock,
    output logic [3:0]                                       slv_arcache,
    output logic [2:0]                                       slv_arprot,
    output logic [3:0]                                       slv_arqos,
    output logic                                             slv_arvalid,
    input  logic                                             slv_arready,
    input  logic [AXI_ID_WIDTH_P-1:0]                        slv_rid,
    input  logic [AXI_DATA_WIDTH_P-1:0]                      slv_rdata,
    input  logic [1:0]                                       slv_rresp,
    input  logic                                             slv_rlast,
    input  logic                                             slv_rvalid,
    output logic                                             slv_rready,
    output logic                                             rd_len_error
);

    localparam int              SEL_W  = $clog2(NR_OF_MASTERS_P);
    localparam logic [SEL_W-1:0] LAST_C = SEL_W'(NR_OF_MASTERS_P - 1);

    read_arb_state_t  r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_rr_ptr;
    logic             w_any_req;
    logic [SEL_W-1:0] w_grant;
    logic             w_ar_hs;
    logic             w_r_hs;

    assign slv_arsize  = 3'($clog2(AXI_DATA_WIDTH_P / 8));
    assign slv_arburst = AXI4_BURST_INCR_C;
    assign slv_arlock  = 1'b0;
    assign slv_arcache = 4'd0;
    assign slv_arprot  = 3'd0;
    assign slv_arqos   = 4'd0;

    assign w_ar_hs = (r_state == AR_PHASE_E) && mst_arvalid[r_sel] && slv_arready;
    assign w_r_hs  = (r_state == R_PHASE_E) && slv_rvalid && mst_rready[r_sel];

    rr_priority_select #(
        .N (NR_OF_MASTERS_P)
    ) u_rr_sel (
        .i_req     (mst_arvalid),
        .i_rr_ptr  (r_rr_ptr),
        .o_any_req (w_any_req),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE_E;
            r_sel    <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE_E: begin
                    if (w_any_req) begin
                        r_sel   <= w_grant;
                        r_state <= AR_PHASE_E;
                    end
                end
                AR_PHASE_E: begin
                    if (w_ar_hs) begin
                        r_state <= R_PHASE_E;
                    end
                end
                R_PHASE_E: begin
                    if (w_r_hs && slv_rlast) begin
                        r_state  <= IDLE_E;
                        r_rr_ptr <= (r_sel == LAST_C) ? '0 : r_sel + 1'b1;
                    end
                end
                default: r_state <= IDLE_E;
            endcase
        end
    end

    // Channel muxing; everything not owned by the current phase is held at zero.
    always_comb begin
        slv_arid    = '0;
        slv_araddr  = '0;
        slv_arlen   = '0;
        slv_arvalid = 1'b0;
        mst_arready = '0;
        mst_rid     = '0;
        mst_rdata   = '0;
        mst_rresp   = '0;
        mst_rlast   = 1'b0;
        mst_rvalid  = '0;
        slv_rready  = 1'b0;
        if (r_state == AR_PHASE_E) begin
            slv_arid           = mst_arid[r_sel];
            slv_araddr         = mst_araddr[r_sel];
            slv_arlen          = mst_arlen[r_sel];
            slv_arvalid        = mst_arvalid[r_sel];
            mst_arready[r_sel] = slv_arready;
        end
        if (r_state == R_PHASE_E) begin
            mst_rid           = slv_rid;
            mst_rdata         = slv_rdata;
            mst_rresp         = slv_rresp;
            mst_rlast         = slv_rlast;
            mst_rvalid[r_sel] = slv_rvalid;
            slv_rready        = mst_rready[r_sel];
        end
    end

`ifdef AXI4_RD_ARB_BEAT_CHECK_EN
    logic [7:0]                   r_arlen;
    logic [AXI4_BEAT_CNT_W_C-1:0] r_beat_cnt;
    logic                         r_len_err;
    logic [AXI4_BEAT_CNT_W_C-1:0] w_beat;
    logic [AXI4_BEAT_CNT_W_C-1:0] w_exp_beats;

    assign w_beat      = r_beat_cnt + 9'd1;
    assign w_exp_beats = {1'b0, r_arlen} + 9'd1;

    // rlast must coincide exactly with beat arlen+1; either mismatch direction is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arlen    <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arlen    <= mst_arlen[r_sel];
                r_beat_cnt <= '0;
            end
            if (w_r_hs) begin
                r_beat_cnt <= w_beat;
                if (slv_rlast != (w_beat == w_exp_beats)) begin
                    r_len_err <= 1'b1;
                end
            end
        end
    end

    assign rd_len_error = r_len_err;
`else
    assign rd_len_error = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_m2s_read_arbiter.sv
// Scoreboard bench for the read arbiter: N=4 main instance plus an N=3 instance for wrap-around.
module tb_axi4_m2s_read_arbiter;

    localparam int N = 4;
`ifdef AXI4_RD_ARB_BEAT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0][2:0]  mst_arid;
    logic [N-1:0][31:0] mst_araddr;
    logic [N-1:0][7:0]  mst_arlen;
    logic [N-1:0]       mst_arvalid, mst_arready, mst_rvalid, mst_rready;
    logic [2:0]         mst_rid, slv_arid, slv_rid, slv_arsize, slv_arprot;
    logic [31:0]        mst_rdata, slv_araddr, slv_rdata;
    logic [1:0]         mst_rresp, slv_arburst, slv_rresp;
    logic               mst_rlast, slv_arlock, slv_arvalid, slv_arready;
    logic [7:0]         slv_arlen;
    logic [3:0]         slv_arcache, slv_arqos;
    logic               slv_rlast, slv_rvalid, slv_rready, rd_len_error;

    logic [2:0][2:0]  t3_arid;
    logic [2:0][31:0] t3_araddr;
    logic [2:0][7:0]  t3_arlen;
    logic [2:0]       t3_arvalid, t3_arready, t3_rvalid, t3_rready;
    logic [2:0]       t3_rid, t3_s_arid, t3_s_arsize, t3_s_arprot;
    logic [31:0]      t3_rdata, t3_s_araddr;
    logic [1:0]       t3_rresp, t3_s_arburst;
    logic             t3_rlast, t3_s_arlock, t3_s_arvalid, t3_s_arready;
    logic [7:0]       t3_s_arlen;
    logic [3:0]       t3_s_arcache, t3_s_arqos;
    logic             t3_s_rlast, t3_s_rvalid, t3_s_rready, t3_len_err;

    int total = 0;
    int bad   = 0;
    int          exp_ar_q[$];
    logic [35:0] exp_r_q[$];

    axi4_m2s_read_arbiter #(.NR_OF_MASTERS_P(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
        .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
        .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
        .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
        .slv_arid(slv_arid), .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
        .slv_arburst(slv_arburst), .slv_arlock(slv_arlock), .slv_arcache(slv_arcache),
        .slv_arprot(slv_arprot), .slv_arqos(slv_arqos), .slv_arvalid(slv_arvalid),
        .slv_arready(slv_arready), .slv_rid(slv_rid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp),
        .slv_rlast(slv_rlast), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
        .rd_len_error(rd_len_error)
    );

    axi4_m2s_read_arbiter #(.NR_OF_MASTERS_P(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .mst_arid(t3_arid), .mst_araddr(t3_araddr), .mst_arlen(t3_arlen),
        .mst_arvalid(t3_arvalid), .mst_arready(t3_arready),
        .mst_rid(t3_rid), .mst_rdata(t3_rdata), .mst_rresp(t3_rresp), .mst_rlast(t3_rlast),
        .mst_rvalid(t3_rvalid), .mst_rready(t3_rready),
        .slv_arid(t3_s_arid), .slv_araddr(t3_s_araddr), .slv_arlen(t3_s_arlen), .slv_arsize(t3_s_arsize),
        .slv_arburst(t3_s_arburst), .slv_arlock(t3_s_arlock), .slv_arcache(t3_s_arcache),
        .slv_arprot(t3_s_arprot), .slv_arqos(t3_s_arqos), .slv_arvalid(t3_s_arvalid),
        .slv_arready(t3_s_arready), .slv_rid(3'd0), .slv_rdata(32'h0), .slv_rresp(2'd0),
        .slv_rlast(t3_s_rlast), .slv_rvalid(t3_s_rvalid), .slv_rready(t3_s_rready),
        .rd_len_error(t3_len_err)
    );

    function automatic logic [31:0] addr_of(input int m);
        return 32'h1000_0000 + 32'(m) * 32'h100;
    endfunction

    // Waits for AR, handshakes after ar_stall cycles, returns last_at+1 beats, drops rready on drop_beat.
    task automatic do_burst(input int len, input int last_at, input int ar_stall,
                            input int drop_beat, input bit keep);
        int m;
        bit seen;
        logic [35:0] e;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (slv_arvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ar_timeout slv_arvalid=%0b required 1", slv_arvalid);
            return;
        end
        m = exp_ar_q.pop_front();
        total++;
        if (slv_araddr !== addr_of(m)) begin
            bad++;
            $display("FAIL grant_addr got %h required %h (master %0d)", slv_araddr, addr_of(m), m);
        end
        for (int s = 0; s < ar_stall; s++) begin
            total++;
            if (mst_arready !== 4'b0) begin
                bad++;
                $display("FAIL arready_stall got %b required 0000", mst_arready);
            end
            @(negedge clk); #1;
        end
        slv_arready = 1'b1;
        #1;
        total++;
        if (mst_arready !== 4'(1 << m) || slv_arlen !== 8'(len)) begin
            bad++;
            $display("FAIL ar_hs arready=%b arlen=%0d required %b / %0d", mst_arready, slv_arlen, 4'(1 << m), len);
        end
        @(negedge clk);
        slv_arready = 1'b0;
        if (!keep) mst_arvalid[m] = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            slv_rvalid = 1'b1;
            slv_rid    = 3'(m);
            slv_rdata  = 32'hD000_0000 | (32'(m) << 8) | 32'(i);
            slv_rlast  = (i == last_at);
            exp_r_q.push_back({4'(m), slv_rdata});
            if (i == drop_beat) begin
                mst_rready[m] = 1'b0;
                #1;
                total++;
                if (slv_rready !== 1'b0) begin
                    bad++;
                    $display("FAIL rready_drop slv_rready=%b required 0", slv_rready);
                end
                @(negedge clk);
                mst_rready[m] = 1'b1;
            end
            #1;
            e = exp_r_q.pop_front();
            total++;
            if (mst_rvalid !== 4'(1 << e[35:32]) || mst_rdata !== e[31:0]) begin
                bad++;
                $display("FAIL r_beat%0d rvalid=%b rdata=%h required %b / %h", i, mst_rvalid, mst_rdata,
                         4'(1 << e[35:32]), e[31:0]);
            end
            @(negedge clk);
        end
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        #1;
        total++;
        if (mst_rvalid !== 4'b0 || slv_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL idle_gap rvalid=%b arvalid=%b required 0000 / 0", mst_rvalid, slv_arvalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mst_arvalid = '0; mst_rready = '1; mst_arlen = '0;
        slv_arready = 1'b0; slv_rvalid = 1'b0; slv_rlast = 1'b0; slv_rdata = '0; slv_rid = '0; slv_rresp = '0;
        t3_arvalid = '0; t3_rready = '1; t3_arlen = '0;
        t3_s_arready = 1'b0; t3_s_rvalid = 1'b0; t3_s_rlast = 1'b0;
        for (int m = 0; m < N; m++) begin
            mst_araddr[m] = addr_of(m);
            mst_arid[m]   = 3'(m);
        end
        for (int m = 0; m < 3; m++) begin
            t3_araddr[m] = addr_of(m);
            t3_arid[m]   = 3'(m);
        end
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (slv_arvalid !== 1'b0 || mst_arready !== 4'b0 || mst_rvalid !== 4'b0 || slv_rready !== 1'b0
            || slv_araddr !== 32'h0 || rd_len_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs arvalid=%b arready=%b rvalid=%b rready=%b araddr=%h err=%b required all 0",
                     slv_arvalid, mst_arready, mst_rvalid, slv_rready, slv_araddr, rd_len_error);
        end
        total++;
        if (slv_arsize !== 3'd2 || slv_arburst !== 2'b01 || slv_arcache !== 4'd0 || slv_arqos !== 4'd0) begin
            bad++;
            $display("FAIL const_ar arsize=%0d arburst=%b required 2 / 01", slv_arsize, slv_arburst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        mst_arlen[2]   = 8'd3;
        mst_arvalid[2] = 1'b1;
        exp_ar_q.push_back(2);
        #1;
        total++;
        if (slv_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL latency_t0 slv_arvalid=%b required 0", slv_arvalid);
        end
        @(negedge clk); #1;
        total++;
        if (slv_arvalid !== 1'b1) begin
            bad++;
            $display("FAIL latency_t1 slv_arvalid=%b required 1", slv_arvalid);
        end
        do_burst(3, 3, 0, -1, 1'b0);
    endtask

    task automatic test_ar_stall();
        mst_arlen[1]   = 8'd1;
        mst_arvalid[1] = 1'b1;
        exp_ar_q.push_back(1);
        do_burst(1, 1, 5, -1, 1'b0);
    endtask

    task automatic test_rready_drop();
        mst_arlen[3]   = 8'd3;
        mst_arvalid[3] = 1'b1;
        exp_ar_q.push_back(3);
        do_burst(3, 3, 0, 1, 1'b0);
    endtask

    task automatic test_round_robin();
        mst_arlen   = '0;
        mst_arvalid = '1;
        for (int k = 0; k < 8; k++) exp_ar_q.push_back(k % N);
        for (int k = 0; k < 8; k++) do_burst(0, 0, 0, -1, 1'b1);
        mst_arvalid = '0;
    endtask

    task automatic test_wrap_n3();
        int q3[$];
        int e;
        bit seen;
        q3.push_back(0); q3.push_back(2); q3.push_back(0);
        t3_arvalid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (t3_s_arvalid) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk); #1;
            end
            e = q3.pop_front();
            total++;
            if (!seen || t3_s_araddr !== addr_of(e)) begin
                bad++;
                $display("FAIL n3_grant%0d seen=%b araddr=%h required %h", k, seen, t3_s_araddr, addr_of(e));
            end
            t3_s_arready = 1'b1;
            #1;
            total++;
            if (t3_arready !== 3'(1 << e)) begin
                bad++;
                $display("FAIL n3_arready%0d got %b required %b", k, t3_arready, 3'(1 << e));
            end
            @(negedge clk);
            t3_s_arready = 1'b0;
            t3_s_rvalid  = 1'b1;
            t3_s_rlast   = 1'b1;
            #1;
            total++;
            if (t3_rvalid !== 3'(1 << e)) begin
                bad++;
                $display("FAIL n3_rvalid%0d got %b required %b", k, t3_rvalid, 3'(1 << e));
            end
            @(negedge clk);
            t3_s_rvalid = 1'b0;
            t3_s_rlast  = 1'b0;
            if (k == 2) t3_arvalid = '0;
            #1;
        end
    endtask

    task automatic test_len_error();
        mst_arlen[0]   = 8'd3;
        mst_arvalid[0] = 1'b1;
        exp_ar_q.push_back(0);
        do_burst(3, 1, 0, -1, 1'b0);
        total++;
        if (rd_len_error !== EXP_ERR) begin
            bad++;
            $display("FAIL len_error_set got %b required %b", rd_len_error, EXP_ERR);
        end
        mst_arlen[1]   = 8'd0;
        mst_arvalid[1] = 1'b1;
        exp_ar_q.push_back(1);
        do_burst(0, 0, 0, -1, 1'b0);
        total++;
        if (rd_len_error !== EXP_ERR) begin
            bad++;
            $display("FAIL len_error_sticky got %b required %b", rd_len_error, EXP_ERR);
        end
    endtask

    task automatic test_reset_mid_burst();
        mst_arlen[2]   = 8'd3;
        mst_arvalid[2] = 1'b1;
        @(negedge clk); #1;
        slv_arready = 1'b1;
        @(negedge clk);
        slv_arready    = 1'b0;
        mst_arvalid[2] = 1'b0;
        slv_rvalid     = 1'b1;
        slv_rdata      = 32'hCAFE_0002;
        #1;
        total++;
        if (mst_rvalid !== 4'b0100) begin
            bad++;
            $display("FAIL mid_burst_rvalid got %b required 0100", mst_rvalid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (mst_rvalid !== 4'b0 || slv_rready !== 1'b0 || mst_rdata !== 32'h0 || rd_len_error !== 1'b0) begin
            bad++;
            $display("FAIL mid_burst_reset rvalid=%b rready=%b rdata=%h err=%b required 0000/0/0/0",
                     mst_rvalid, slv_rready, mst_rdata, rd_len_error);
        end
        slv_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_ar_stall();
        test_rready_drop();
        test_round_robin();
        test_wrap_n3();
        test_len_error();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
